// File: rtl/ais_sample_framer_if.sv
// AXI4-Stream beat bundle carrying one framed sample: data, in-window index and end-of-window marker.
interface ais_sample_framer_if #(
    parameter int DATA_WIDTH = 16,
    parameter int USER_WIDTH = 7
);
    logic                  tvalid;
    logic                  tready;
    logic                  tlast;
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;

    modport master (output tvalid, tlast, tdata, tuser, input tready);
    modport slave  (input tvalid, tlast, tdata, tuser, output tready);
endinterface

// File: rtl/ais_sample_framer.sv
// Cuts a free-running sample stream into fixed windows of AXIS beats, zero-padding aborted windows.
// Latency 1 cycle into an empty 2-entry buffer; input cannot stall, so samples are dropped when it is full.
module ais_sample_framer #(
    parameter int PAR_DATA_WIDTH = 16,
    parameter int PAR_WINDOW_LEN = 128,
    parameter int PAR_USER_WIDTH = $clog2(PAR_WINDOW_LEN),
    parameter int PAR_CNT_WIDTH  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst,
    input  logic                      i_en,
    input  logic                      i_flush,
    input  logic                      i_smp_vld,
    input  logic [PAR_DATA_WIDTH-1:0] i_smp_dat,
    ais_sample_framer_if.master       m_axis,
    output logic                      o_busy,
    output logic                      o_overflow,
    output logic [PAR_CNT_WIDTH-1:0]  o_drop_cnt
);
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAD} state_t;

    typedef struct packed {
        logic [PAR_DATA_WIDTH-1:0] dat;
        logic [PAR_USER_WIDTH-1:0] user;
        logic                      last;
    } beat_t;

    localparam logic [PAR_USER_WIDTH-1:0] LAST_IDX = PAR_USER_WIDTH'(PAR_WINDOW_LEN - 1);

    state_t                    state_q, state_d;
    logic [PAR_USER_WIDTH-1:0] idx_q, idx_d;
    beat_t                     mem_q [2];
    logic                      wr_ptr_q, rd_ptr_q;
    logic [1:0]                fill_q;
    logic [PAR_CNT_WIDTH-1:0]  drop_cnt_q;
    logic                      overflow_q;

    logic  pop, push, drop, slot_free, term;
    beat_t push_beat;

    assign pop       = (fill_q != 2'd0) && m_axis.tready;
    assign slot_free = (fill_q != 2'd2) || pop;
    assign term      = i_flush || !i_en;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        push      = 1'b0;
        drop      = 1'b0;
        push_beat = '0;
        unique case (state_q)
            ST_IDLE: begin
                if (i_en) begin
                    state_d = ST_RUN;
                    idx_d   = '0;
                end
            end
            ST_RUN: begin
                if (term && idx_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    if (i_smp_vld) begin
                        if (slot_free) begin
                            push           = 1'b1;
                            push_beat.dat  = i_smp_dat;
                            push_beat.user = idx_q;
                            push_beat.last = (idx_q == LAST_IDX);
                            idx_d          = idx_q + 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                    // A same-cycle sample that completes the window leaves nothing to pad.
                    if (term) begin
                        state_d = (idx_d != '0) ? ST_PAD : (i_en ? ST_RUN : ST_IDLE);
                    end
                end
            end
            ST_PAD: begin
                drop = i_smp_vld;
                if (slot_free) begin
                    push           = 1'b1;
                    push_beat.user = idx_q;
                    push_beat.last = (idx_q == LAST_IDX);
                    idx_d          = idx_q + 1'b1;
                    if (idx_q == LAST_IDX) begin
                        state_d = i_en ? ST_RUN : ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // When full, a push lands in the slot being popped this same cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            fill_q     <= 2'd0;
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            drop_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            if (push) begin
                mem_q[wr_ptr_q] <= push_beat;
                wr_ptr_q        <= !wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= !rd_ptr_q;
            end
            fill_q <= fill_q + 2'(push) - 2'(pop);
            if (drop) begin
                overflow_q <= 1'b1;
                if (drop_cnt_q != '1) begin
                    drop_cnt_q <= drop_cnt_q + 1'b1;
                end
            end
        end
    end

    assign m_axis.tvalid = (fill_q != 2'd0);
    assign m_axis.tdata  = mem_q[rd_ptr_q].dat;
    assign m_axis.tuser  = mem_q[rd_ptr_q].user;
    assign m_axis.tlast  = mem_q[rd_ptr_q].last;
    assign o_busy        = (state_q != ST_IDLE);
    assign o_overflow    = overflow_q;
    assign o_drop_cnt    = drop_cnt_q;
endmodule
